tamagotchi_modos: RTL and testbench

Status/mode core of the Tamagotchi pet: keeps four 2-bit need levels (Energia, Medicina, Descanso, Animo), decays them on a periodic time tick, and raises them from user buttons and sensor inputs. Sits between the input-conditioning front end (buttons, rest/mood sensors) and the LED/display back end. A test mode shortens the tick period so behaviour can be shown quickly.

---
 rtl/tamagotchi_modos_if.sv | 22 ++
 rtl/tamagotchi_modos.sv | 84 ++++++++
 tb/tb_tamagotchi_modos.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/tamagotchi_modos_if.sv
// rtl/tamagotchi_modos_if.sv - button/sensor inputs and LED level outputs of the pet status core
interface tamagotchi_modos_if;
  logic       B_Test;
  logic       B_Energia;
  logic       B_Medicina;
  logic       Entrada_Descanso;
  logic       Entrada_Animo;
  logic [0:1] LED_Energia;
  logic [0:1] LED_Medicina;
  logic [0:1] LED_Descanso;
  logic [0:1] LED_Animo;

  modport master (
    output B_Test, B_Energia, B_Medicina, Entrada_Descanso, Entrada_Animo,
    input  LED_Energia, LED_Medicina, LED_Descanso, LED_Animo
  );

  modport slave (
    input  B_Test, B_Energia, B_Medicina, Entrada_Descanso, Entrada_Animo,
    output LED_Energia, LED_Medicina, LED_Descanso, LED_Animo
  );
endinterface

// File: rtl/tamagotchi_modos.sv
// rtl/tamagotchi_modos.sv - four saturating 2-bit need levels with tick decay and button/sensor recovery
module tamagotchi_modos #(
  parameter int DECAY_PERIOD = 2000,
  parameter int TEST_PERIOD  = 20
) (
  input logic               clk,
  input logic               B_Reset,
  tamagotchi_modos_if.slave io
);
  localparam int MAXP = (DECAY_PERIOD > TEST_PERIOD) ? DECAY_PERIOD : TEST_PERIOD;
  localparam int CW   = $clog2(MAXP);
  localparam logic [CW-1:0] DECAY_LAST = CW'(DECAY_PERIOD - 1);
  localparam logic [CW-1:0] TEST_LAST  = CW'(TEST_PERIOD - 1);

  // bit order: {animo, descanso, medicina, energia, test}
  logic [4:0]    sync1_q, sync1_d, sync2_q, sync2_d;
  logic [2:0]    prev_q, prev_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    en_q, en_d, med_q, med_d, desc_q, desc_d, ani_q, ani_d;

  logic          tick, test_chg, press_en, press_med;
  logic [CW-1:0] last;

  function automatic logic [1:0] next_level(input logic [1:0] lvl, input logic inc, input logic dec);
    if (inc && !dec && lvl != 2'd3)
      return lvl + 2'd1;
    else if (dec && !inc && lvl != 2'd0)
      return lvl - 2'd1;
    else
      return lvl;
  endfunction

  always_comb begin
    sync1_d   = {io.Entrada_Animo, io.Entrada_Descanso, io.B_Medicina, io.B_Energia, io.B_Test};
    sync2_d   = sync1_q;
    prev_d    = sync2_q[2:0];
    press_en  = sync2_q[1] && !prev_q[1];
    press_med = sync2_q[2] && !prev_q[2];
    test_chg  = sync2_q[0] != prev_q[0];
    last      = sync2_q[0] ? TEST_LAST : DECAY_LAST;

    // A mode change restarts the period so the next tick lands P_new cycles later
    tick  = 1'b0;
    cnt_d = cnt_q + 1'b1;
    if (test_chg) begin
      cnt_d = '0;
    end else if (cnt_q >= last) begin
      tick  = 1'b1;
      cnt_d = '0;
    end

    en_d   = next_level(en_q, press_en, tick);
    med_d  = next_level(med_q, press_med, tick);
    desc_d = next_level(desc_q, tick && sync2_q[3], tick && !sync2_q[3]);
    ani_d  = next_level(ani_q, tick && sync2_q[4], tick && !sync2_q[4]);
  end

  always_ff @(posedge clk or posedge B_Reset) begin
    if (B_Reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      cnt_q   <= '0;
      en_q    <= 2'd3;
      med_q   <= 2'd3;
      desc_q  <= 2'd3;
      ani_q   <= 2'd3;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      med_q   <= med_d;
      desc_q  <= desc_d;
      ani_q   <= ani_d;
    end
  end

  assign io.LED_Energia  = en_q;
  assign io.LED_Medicina = med_q;
  assign io.LED_Descanso = desc_q;
  assign io.LED_Animo    = ani_q;
endmodule

// File: tb/tb_tamagotchi_modos.sv
// tb/tb_tamagotchi_modos.sv - directed and randomized checks of tamagotchi_modos against an edge-indexed reference model
module tb_tamagotchi_modos;
  localparam int DP = 60;
  localparam int TP = 20;

  logic clk = 1'b0;
  logic B_Reset = 1'b0;
  tamagotchi_modos_if io ();

  tamagotchi_modos #(.DECAY_PERIOD(DP), .TEST_PERIOD(TP)) dut (
    .clk     (clk),
    .B_Reset (B_Reset),
    .io      (io)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference: inputs seen at edge n act at edge n+2; ticks fall P edges after the last restart point
  int   m_e, m_m, m_d, m_a;
  int   edge_n, restart_n, per;
  bit   tick, chg, pe, pm;
  logic [4:0] a1, a2, a3;

  function automatic int clampv(input int v);
    return (v < 0) ? 0 : ((v > 3) ? 3 : v);
  endfunction

  always @(posedge clk or posedge B_Reset) begin
    if (B_Reset) begin
      m_e = 3; m_m = 3; m_d = 3; m_a = 3;
      edge_n = 0; restart_n = 0;
      a1 = '0; a2 = '0; a3 = '0;
    end else begin
      edge_n = edge_n + 1;
      per  = a2[0] ? TP : DP;
      chg  = a2[0] != a3[0];
      tick = 1'b0;
      if (chg) begin
        restart_n = edge_n;
      end else if (edge_n - restart_n == per) begin
        tick = 1'b1;
        restart_n = edge_n;
      end
      pe = a2[1] && !a3[1];
      pm = a2[2] && !a3[2];
      m_e = clampv(m_e + int'(pe) - int'(tick));
      m_m = clampv(m_m + int'(pm) - int'(tick));
      m_d = clampv(m_d + ((tick && a2[3]) ? 1 : 0) - ((tick && !a2[3]) ? 1 : 0));
      m_a = clampv(m_a + ((tick && a2[4]) ? 1 : 0) - ((tick && !a2[4]) ? 1 : 0));
      a3 = a2;
      a2 = a1;
      a1 = {io.Entrada_Animo, io.Entrada_Descanso, io.B_Medicina, io.B_Energia, io.B_Test};
    end
  end

  task automatic chk(input string tag, input logic [1:0] obs, input int exp);
    logic [1:0] e;
    e = 2'(exp);
    checks++;
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, e);
    end
  endtask

  task automatic chk_model();
    chk("energia", io.LED_Energia, m_e);
    chk("medicina", io.LED_Medicina, m_m);
    chk("descanso", io.LED_Descanso, m_d);
    chk("animo", io.LED_Animo, m_a);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk_model();
    end
  endtask

  initial begin
    io.B_Test = 0; io.B_Energia = 0; io.B_Medicina = 0;
    io.Entrada_Descanso = 0; io.Entrada_Animo = 0;
    #1 B_Reset = 1'b1;
    #1;
    chk("rst_energia", io.LED_Energia, 3);
    chk("rst_medicina", io.LED_Medicina, 3);
    chk("rst_descanso", io.LED_Descanso, 3);
    chk("rst_animo", io.LED_Animo, 3);

    @(negedge clk);
    B_Reset = 1'b0;
    io.B_Test = 1;
    run(100);
    chk("decay_energia", io.LED_Energia, 0);
    chk("decay_medicina", io.LED_Medicina, 0);
    chk("decay_descanso", io.LED_Descanso, 0);
    chk("decay_animo", io.LED_Animo, 0);

    io.B_Energia = 1; io.B_Medicina = 1;
    run(50);
    for (int k = 0; k < 3; k++) begin
      io.B_Energia = 0; io.B_Medicina = 0;
      run(1);
      io.B_Energia = 1; io.B_Medicina = 1;
      run(1);
    end
    for (int k = 0; k < 4; k++) begin
      io.B_Energia = 0;
      run(1);
      io.B_Energia = 1;
      run(1);
    end
    io.B_Energia = 0; io.B_Medicina = 0;
    run(5);

    io.Entrada_Descanso = 1;
    run(100);
    chk("sensor_descanso", io.LED_Descanso, 3);
    chk("sensor_animo", io.LED_Animo, 0);

    io.Entrada_Descanso = 0;
    run(100);
    #2 B_Reset = 1'b1;
    #1;
    chk("async_energia", io.LED_Energia, 3);
    chk("async_medicina", io.LED_Medicina, 3);
    chk("async_descanso", io.LED_Descanso, 3);
    chk("async_animo", io.LED_Animo, 3);
    @(negedge clk);
    B_Reset = 1'b0;

    io.B_Test = 0;
    run(30);
    io.B_Test = 1;
    run(47);
    io.B_Test = 0;
    run(130);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(3) == 0) io.B_Energia = ~io.B_Energia;
      if ($urandom_range(3) == 0) io.B_Medicina = ~io.B_Medicina;
      if ($urandom_range(15) == 0) io.Entrada_Descanso = ~io.Entrada_Descanso;
      if ($urandom_range(15) == 0) io.Entrada_Animo = ~io.Entrada_Animo;
      if ($urandom_range(199) == 0) io.B_Test = ~io.B_Test;
      run(1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
